multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS core. Breaks each instruction into FETCH/DECODE/EXEC/MEM/WB

---
 rtl/mips_ctrl_pkg.sv | 21 ++
 rtl/mem_timeout_cnt.sv | 32 +++
 rtl/multicycle_ctrl.sv | 134 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS sequencer: state encoding and widths.
package mips_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int TMO_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_EXC    = 3'd6
    } state_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts cycles of an outstanding memory access; flags expiry on the last allowed cycle.
module mem_timeout_cnt
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [TMO_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clear) begin
            cnt <= '0;
        end else if (i_enable && (cnt != LAST)) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // Holds cnt at LAST, the cycle on which the access is abandoned unless ready arrives.
    assign o_expired = (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB on a
// single shared memory port and owns every state-changing write enable.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_is_load,
    input  logic               i_is_store,
    input  logic               i_regWrite,
    input  logic               i_pcChange,
    input  logic               i_exception,
    input  logic               i_mem_ready,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic               o_ir_we,
    output logic               o_reg_we,
    output logic               o_pc_we,
    output logic               o_epc_we,
    output logic               o_bus_error,
    output logic [STATE_W-1:0] o_state,
    output logic [CNT_W-1:0]   o_instr_cnt
);

    state_t state, state_nxt;
    logic   expired;
    logic   timeout;
    logic   in_access;

    assign in_access = is_mem_state(state);

    mem_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (!in_access || i_mem_ready),
        .i_enable  (in_access && !i_mem_ready),
        .o_expired (expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            o_bus_error <= 1'b0;
            o_instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (timeout) begin
                o_bus_error <= 1'b1;
            end
            if (o_pc_we && (state != ST_EXC)) begin
                o_instr_cnt <= o_instr_cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        o_mem_req = 1'b0;
        o_mem_we  = 1'b0;
        o_ir_we   = 1'b0;
        o_reg_we  = 1'b0;
        o_pc_we   = 1'b0;
        o_epc_we  = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_we   = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = ST_EXC;
                end
            end
            ST_DECODE: begin
                state_nxt = i_exception ? ST_EXC : ST_EXEC;
            end
            ST_EXEC: begin
                if (i_exception) begin
                    state_nxt = ST_EXC;
                end else if (i_pcChange) begin
                    o_pc_we   = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (i_is_load || i_is_store) begin
                    state_nxt = ST_MEM;
                end else if (i_regWrite) begin
                    state_nxt = ST_WB;
                end else begin
                    o_pc_we   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_MEM: begin
                // Late exceptions are ignored here: the access commits the instruction.
                o_mem_req = 1'b1;
                o_mem_we  = i_is_store;
                if (i_mem_ready) begin
                    if (i_is_store) begin
                        o_pc_we   = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else if (expired) begin
                    timeout   = 1'b1;
                    state_nxt = ST_EXC;
                end
            end
            ST_WB: begin
                o_reg_we  = 1'b1;
                o_pc_we   = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_EXC: begin
                o_epc_we  = 1'b1;
                o_pc_we   = 1'b1;
                state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_state = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected state/strobes go through a scoreboard queue.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [2:0]       st;
        logic [5:0]       strobes;  // {mem_req, mem_we, ir_we, reg_we, pc_we, epc_we}
        logic             bus_err;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start, is_load, is_store, reg_write, pc_change, exception, mem_ready;
    logic mem_req, mem_we, ir_we, reg_we, pc_we, epc_we, bus_error;
    logic [2:0] state;
    logic [CNT_W-1:0] instr_cnt;

    int checks = 0;
    int errors = 0;
    int cnt_exp = 0;
    logic be_exp = 1'b0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_is_load   (is_load),
        .i_is_store  (is_store),
        .i_regWrite  (reg_write),
        .i_pcChange  (pc_change),
        .i_exception (exception),
        .i_mem_ready (mem_ready),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_ir_we     (ir_we),
        .o_reg_we    (reg_we),
        .o_pc_we     (pc_we),
        .o_epc_we    (epc_we),
        .o_bus_error (bus_error),
        .o_state     (state),
        .o_instr_cnt (instr_cnt)
    );

    // Input vector order: {start, is_load, is_store, regWrite, pcChange, exception, mem_ready}
    task automatic drive(input logic [6:0] v);
        {start, is_load, is_store, reg_write, pc_change, exception, mem_ready} = v;
    endtask

    task automatic check(input string tag, input logic [2:0] st, input logic [5:0] s);
        obs_t e, obs;
        e.st      = st;
        e.strobes = s;
        e.bus_err = be_exp;
        e.cnt     = CNT_W'(cnt_exp);
        exp_q.push_back(e);
        #1;
        obs = {state, {mem_req, mem_we, ir_we, reg_we, pc_we, epc_we}, bus_error, instr_cnt};
        e = exp_q.pop_front();
        checks++;
        assert (obs === e)
        else begin
            errors++;
            $error("FAIL %s observed st=%0d strb=%b be=%b cnt=%0d expected st=%0d strb=%b be=%b cnt=%0d",
                   tag, obs.st, obs.strobes, obs.bus_err, obs.cnt, e.st, e.strobes, e.bus_err, e.cnt);
        end
    endtask

    // One clock cycle: drive inputs, check combinational strobes, then step past the edge.
    task automatic cyc(input string tag, input logic [6:0] v, input logic [2:0] st, input logic [5:0] s);
        drive(v);
        check(tag, st, s);
        @(negedge clk);
        #1;
        if (s[1] && (st != 3'd6)) cnt_exp = (cnt_exp + 1) % (1 << CNT_W);
    endtask

    localparam logic [6:0] RDY = 7'b0000001;
    localparam logic [5:0] S_FETCH    = 6'b100000;
    localparam logic [5:0] S_FETCH_OK = 6'b101000;
    localparam logic [5:0] S_PC       = 6'b000010;
    localparam logic [5:0] S_WB       = 6'b000110;
    localparam logic [5:0] S_EXC      = 6'b000011;
    localparam logic [5:0] S_STORE    = 6'b110000;

    initial begin
        rst_n = 1'b0;
        drive(7'b0);
        @(negedge clk);
        #1;
        cyc("reset", 7'b0, 3'd0, 6'b0);
        rst_n = 1'b1;
        cyc("idle_hold", 7'b0, 3'd0, 6'b0);
        cyc("idle_start", 7'b1000000, 3'd0, 6'b0);

        // R-type add, memory ready immediately
        cyc("add_fetch", 7'b0001001, 3'd1, S_FETCH_OK);
        cyc("add_dec", 7'b0001000, 3'd2, 6'b0);
        cyc("add_exec", 7'b0001000, 3'd3, 6'b0);
        cyc("add_wb", 7'b0001000, 3'd5, S_WB);

        // lw, ready after 3 wait cycles in FETCH and MEM
        for (int i = 0; i < 3; i++) cyc("lw_fetch_wait", 7'b0, 3'd1, S_FETCH);
        cyc("lw_fetch_rdy", RDY, 3'd1, S_FETCH_OK);
        cyc("lw_dec", 7'b0101000, 3'd2, 6'b0);
        cyc("lw_exec", 7'b0101000, 3'd3, 6'b0);
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 7'b0101000, 3'd4, S_FETCH);
        cyc("lw_mem_rdy", 7'b0101001, 3'd4, S_FETCH);
        cyc("lw_wb", 7'b0101000, 3'd5, S_WB);

        // sw
        cyc("sw_fetch", RDY, 3'd1, S_FETCH_OK);
        cyc("sw_dec", 7'b0010000, 3'd2, 6'b0);
        cyc("sw_exec", 7'b0010000, 3'd3, 6'b0);
        cyc("sw_mem_wait", 7'b0010000, 3'd4, S_STORE);
        cyc("sw_mem_rdy", 7'b0010001, 3'd4, 6'b110010);

        // overflow in EXEC on a regWrite instruction
        cyc("ovf_fetch", RDY, 3'd1, S_FETCH_OK);
        cyc("ovf_dec", 7'b0001000, 3'd2, 6'b0);
        cyc("ovf_exec", 7'b0001010, 3'd3, 6'b0);
        cyc("ovf_exc", 7'b0001000, 3'd6, S_EXC);

        // taken branch, with a stray regWrite that must lose to pcChange
        cyc("br_fetch", RDY, 3'd1, S_FETCH_OK);
        cyc("br_dec", 7'b0001100, 3'd2, 6'b0);
        cyc("br_exec", 7'b0001100, 3'd3, S_PC);

        // exception seen in DECODE
        cyc("dexc_fetch", RDY, 3'd1, S_FETCH_OK);
        cyc("dexc_dec", 7'b0000010, 3'd2, 6'b0);
        cyc("dexc_exc", 7'b0, 3'd6, S_EXC);

        // ready on the 15th cycle wins over the timeout
        for (int i = 0; i < 14; i++) cyc("tmo_edge_wait", 7'b0, 3'd1, S_FETCH);
        cyc("tmo_edge_rdy", RDY, 3'd1, S_FETCH_OK);
        cyc("tmo_edge_dec", 7'b0, 3'd2, 6'b0);
        cyc("tmo_edge_exec", 7'b0, 3'd3, S_PC);

        // ready held low: 15 cycles then EXC with sticky bus error
        for (int i = 0; i < 15; i++) cyc("tmo_wait", 7'b0, 3'd1, S_FETCH);
        be_exp = 1'b1;
        cyc("tmo_exc", 7'b0, 3'd6, S_EXC);

        // nops to wrap the retired counter; bus error stays set
        for (int i = 0; i < 12; i++) begin
            cyc("nop_fetch", RDY, 3'd1, S_FETCH_OK);
            cyc("nop_dec", 7'b0, 3'd2, 6'b0);
            cyc("nop_exec", 7'b0, 3'd3, S_PC);
        end

        // async reset in the middle of a store access
        cyc("rst_sw_fetch", RDY, 3'd1, S_FETCH_OK);
        cyc("rst_sw_dec", 7'b0010000, 3'd2, 6'b0);
        cyc("rst_sw_exec", 7'b0010000, 3'd3, 6'b0);
        cyc("rst_sw_mem", 7'b0010000, 3'd4, S_STORE);
        rst_n   = 1'b0;
        cnt_exp = 0;
        be_exp  = 1'b0;
        check("rst_async", 3'd0, 6'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rst_idle", 7'b0010000, 3'd0, 6'b0);
        cyc("rst_start", 7'b1000000, 3'd0, 6'b0);
        cyc("rst_fetch", RDY, 3'd1, S_FETCH_OK);
        cyc("rst_dec", 7'b0, 3'd2, 6'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
